huff_decoder: RTL and testbench
===============================

Name: huff_decoder

Overview:
- Serial Huffman decoder, the receive-side counterpart of huff_encoder.
- Holds a code table of up to MAX_CHAR_LENGTH entries, loaded from the encoder's per-symbol encoded_value/encoded_mask outputs. A bit is a 1-bit code digit.
- Consumes a serial bitstream with a valid/ready handshake and emits one 7-bit ASCII symbol per matched codeword, with output backpressure.

Parameters:
- MAX_CHAR_LENGTH, 5, number of code table entries.
- CODE_W, 15, max codeword length in bits; matches the encoder's 2*6+3 value/mask width.
- SYM_W, 7, symbol width (ASCII).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- tbl_we  in  1  table write strobe; honoured only in IDLE.
- tbl_idx  in  $clog2(MAX_CHAR_LENGTH)  table entry index.
- tbl_sym  in  SYM_W  symbol for entry.
- tbl_code  in  CODE_W  codeword (encoded_value format).
- tbl_mask  in  CODE_W  length mask (encoded_mask format, (1<<len)-1); 0 marks the entry invalid.
- start  in  1  pulse; begins decoding.
- stop  in  1  pulse; ends decoding.
- bit_in  in  1  code bit.
- bit_valid  in  1  bit_in valid.
- bit_ready  out  1  decoder accepts a bit.
- sym_out  out  SYM_W  decoded symbol.
- sym_valid  out  1  sym_out valid.
- sym_ready  in  1  downstream accepts the symbol.
- sym_count  out  8  symbols emitted since start; wraps at 255->0.
- err  out  1  sticky decode error.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async): state=IDLE, all table masks=0, acc=0, len=0, sym_out=0, sym_valid=0, sym_count=0, err=0, bit_ready=0, busy=0.
- Bit order: the first received bit is the codeword MSB, i.e. the bit closest to the root. On accept: acc_n = (acc<<1)|bit_in, len_n = len+1.
- Table:
  - Written in IDLE when tbl_we=1 (sym, code, mask at tbl_idx); tbl_we is ignored in every other state.
  - Entries keep their values until reset or an overwrite.
- States: IDLE, DECODE, OUT, ERR.
- IDLE:
  - bit_ready=0.
  - start -> DECODE: clears acc, len, sym_count, err.
  - If start and tbl_we occur in the same cycle, the write completes and the state moves to DECODE.
- DECODE:
  - bit_ready=1. A bit is accepted on bit_valid & bit_ready.
  - Match: a valid entry k with tbl_mask[k] == (1<<len_n)-1 and tbl_code[k] == acc_n. The lowest matching index wins.
  - On match: next cycle sym_out=sym[k], sym_valid=1, acc=0, len=0, state OUT. Latency is 1 cycle after the final bit handshake.
  - No match and len_n == CODE_W: next cycle err=1, state ERR.
  - No match and len_n < CODE_W: acc/len are updated and the state stays DECODE.
  - stop (with no bit accepted that cycle): if len==0, go to IDLE. If len!=0, go to ERR with err=1 (truncated codeword).
  - If stop and a bit handshake occur in the same cycle, the bit is processed first; stop is then honoured in the following DECODE cycle if it is still asserted.
- OUT:
  - bit_ready=0. sym_out and sym_valid are held stable until sym_ready.
  - On sym_valid & sym_ready: sym_valid=0, sym_count+=1, state DECODE.
  - stop is ignored in OUT.
- ERR:
  - bit_ready=0, sym_valid=0, err held.
  - start -> DECODE (clears err, acc, len, sym_count). stop -> IDLE (err stays set).
- Reset mid-operation: everything returns to reset values immediately, including the table.
- A single-entry table with mask 0x1 is legal; each bit equal to the code emits that symbol.

Test Plan:
1. Load the table for "ae aa" and decode.
   - Table: [0]: a=0x61, code 1, mask 0x1. [1]: e=0x65, code 0, mask 0x3. [2]: ' '=0x20, code 1, mask 0x3. [3..4]: mask 0.
   - Stimulus: start, then bits 1,0,0,0,1,1,1 with sym_ready=1.
   - Required: sym_out sequence 0x61, 0x65, 0x20, 0x61, 0x61; each sym_valid 1 cycle after the last bit of its code; sym_count=5; err=0.
2. Same stream with sym_ready=0 for 4 cycles after the first symbol.
   - Required: sym_out=0x61 held with sym_valid=1; bit_ready=0 throughout; decoding resumes after sym_ready with no bits lost.
3. Table with only a (code 1, mask 0x1); feed 15 zero bits.
   - Required: err=1 the cycle after the 15th bit; state ERR; bit_ready=0; no symbol emitted.
4. Table from scenario 1; start, bit 0, then stop.
   - Required: ERR with err=1. A following start clears err, returns to DECODE, sym_count=0.
5. Pulse tbl_we during DECODE with tbl_idx=0, sym=0x7A.
   - Required: the table is unchanged; bit 1 still decodes to 0x61.
6. Assert reset while in OUT.
   - Required: sym_valid=0, busy=0 immediately. All masks=0, so after start, bit 1 then 14 more bits give err=1 at the 15th bit.

Source files
------------

// File: rtl/huff_decoder_if.sv
// Bundles the table-load, bitstream, symbol-stream and status signals of
// huff_decoder so the decoder and its driver share one connection point.
//
//   tbl_we/tbl_idx/tbl_sym/tbl_code/tbl_mask : code table write port
//   start/stop                               : session control pulses
//   bit_in/bit_valid/bit_ready               : serial code-bit handshake
//   sym_out/sym_valid/sym_ready              : decoded symbol handshake
//   sym_count/err/busy                       : status
//
// Modport slave is the decoder's view, master is the driver's view.
interface huff_decoder_if #(
  parameter int MAX_CHAR_LENGTH = 5,
  parameter int CODE_W          = 15,
  parameter int SYM_W           = 7
);
  localparam int IDX_W = (MAX_CHAR_LENGTH > 1) ? $clog2(MAX_CHAR_LENGTH) : 1;

  logic              tbl_we;
  logic [IDX_W-1:0]  tbl_idx;
  logic [SYM_W-1:0]  tbl_sym;
  logic [CODE_W-1:0] tbl_code;
  logic [CODE_W-1:0] tbl_mask;
  logic              start;
  logic              stop;
  logic              bit_in;
  logic              bit_valid;
  logic              bit_ready;
  logic [SYM_W-1:0]  sym_out;
  logic              sym_valid;
  logic              sym_ready;
  logic [7:0]        sym_count;
  logic              err;
  logic              busy;

  modport slave (
    input  tbl_we, tbl_idx, tbl_sym, tbl_code, tbl_mask,
    input  start, stop, bit_in, bit_valid, sym_ready,
    output bit_ready, sym_out, sym_valid, sym_count, err, busy
  );

  modport master (
    output tbl_we, tbl_idx, tbl_sym, tbl_code, tbl_mask,
    output start, stop, bit_in, bit_valid, sym_ready,
    input  bit_ready, sym_out, sym_valid, sym_count, err, busy
  );
endinterface

// File: rtl/huff_decoder.sv
// Serial Huffman decoder. A small code table (symbol, codeword, length mask)
// is loaded while idle; code bits then arrive MSB-first over a valid/ready
// handshake and each completed codeword is emitted as one symbol, held until
// the downstream accepts it.
//
// Ports:
//   clk    : clock
//   reset  : asynchronous active-high reset (clears the table as well)
//   dec    : huff_decoder_if.slave (table port, bit stream, symbol stream,
//            sym_count / err / busy status)
module huff_decoder #(
  parameter int MAX_CHAR_LENGTH = 5,
  parameter int CODE_W          = 15,
  parameter int SYM_W           = 7
) (
  input  logic               clk,
  input  logic               reset,
  huff_decoder_if.slave      dec
);
  localparam int IDX_W = (MAX_CHAR_LENGTH > 1) ? $clog2(MAX_CHAR_LENGTH) : 1;
  localparam int LEN_W = $clog2(CODE_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_OUT, S_ERR} state_t;

  state_t            state_q, state_d;
  logic [CODE_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [SYM_W-1:0]  sym_q, sym_d;
  logic              sym_valid_q, sym_valid_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [SYM_W-1:0]  tbl_sym_q  [MAX_CHAR_LENGTH];
  logic [CODE_W-1:0] tbl_code_q [MAX_CHAR_LENGTH];
  logic [CODE_W-1:0] tbl_mask_q [MAX_CHAR_LENGTH];

  // Candidate accumulator/length if a bit is accepted this cycle.
  logic [CODE_W-1:0] acc_n;
  logic [LEN_W-1:0]  len_n;
  logic [CODE_W-1:0] len_mask;
  logic              hit;
  logic [IDX_W-1:0]  hit_idx;
  logic              bit_acc;
  logic              tbl_wr;

  assign acc_n    = (acc_q << 1) | CODE_W'(dec.bit_in);
  assign len_n    = len_q + LEN_W'(1);
  // (1<<len)-1 in CODE_W bits; len_n is never 0, so an invalid entry
  // (mask 0) can never compare equal.
  assign len_mask = (CODE_W'(1) << len_n) - CODE_W'(1);

  assign bit_acc  = (state_q == S_DECODE) && dec.bit_valid;
  assign tbl_wr   = (state_q == S_IDLE) && dec.tbl_we;

  // Scan from the top down so the lowest matching index is the one kept.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = MAX_CHAR_LENGTH - 1; k >= 0; k--) begin
      if ((tbl_mask_q[k] == len_mask) && (tbl_code_q[k] == acc_n)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(k);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    len_d       = len_q;
    sym_d       = sym_q;
    sym_valid_d = sym_valid_q;
    cnt_d       = cnt_q;
    err_d       = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (dec.start) begin
          state_d = S_DECODE;
          acc_d   = '0;
          len_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end

      S_DECODE: begin
        if (bit_acc) begin
          // A bit arriving alongside stop wins; stop is re-examined next cycle.
          if (hit) begin
            sym_d       = tbl_sym_q[hit_idx];
            sym_valid_d = 1'b1;
            acc_d       = '0;
            len_d       = '0;
            state_d     = S_OUT;
          end else if (len_n == LEN_W'(CODE_W)) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            acc_d = acc_n;
            len_d = len_n;
          end
        end else if (dec.stop) begin
          if (len_q == '0) begin
            state_d = S_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end
        end
      end

      S_OUT: begin
        if (dec.sym_ready) begin
          sym_valid_d = 1'b0;
          cnt_d       = cnt_q + 8'd1;
          state_d     = S_DECODE;
        end
      end

      S_ERR: begin
        if (dec.start) begin
          state_d = S_DECODE;
          acc_d   = '0;
          len_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else if (dec.stop) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      len_q       <= '0;
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      len_q       <= len_d;
      sym_q       <= sym_d;
      sym_valid_q <= sym_valid_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  // Code table; out-of-range indices are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < MAX_CHAR_LENGTH; k++) begin
        tbl_sym_q[k]  <= '0;
        tbl_code_q[k] <= '0;
        tbl_mask_q[k] <= '0;
      end
    end else if (tbl_wr) begin
      for (int k = 0; k < MAX_CHAR_LENGTH; k++) begin
        if (dec.tbl_idx == IDX_W'(k)) begin
          tbl_sym_q[k]  <= dec.tbl_sym;
          tbl_code_q[k] <= dec.tbl_code;
          tbl_mask_q[k] <= dec.tbl_mask;
        end
      end
    end
  end

  assign dec.bit_ready = (state_q == S_DECODE);
  assign dec.sym_out   = sym_q;
  assign dec.sym_valid = sym_valid_q;
  assign dec.sym_count = cnt_q;
  assign dec.err       = err_q;
  assign dec.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_huff_decoder.sv
module tb_huff_decoder;
  localparam int N  = 5;
  localparam int CW = 15;
  localparam int SW = 7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  huff_decoder_if #(.MAX_CHAR_LENGTH(N), .CODE_W(CW), .SYM_W(SW)) bus ();

  huff_decoder #(.MAX_CHAR_LENGTH(N), .CODE_W(CW), .SYM_W(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .dec   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        b;
    logic        ev;
    logic [6:0]  es;
  } vec_t;

  vec_t v [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance past the next rising edge; drive and sample happen here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    int n;
    n = 0;
    while (bus.bit_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) begin
      checks++;
      errors++;
      $display("FAIL bit_ready_timeout: got 0x0 expected 0x1");
    end
    bus.bit_in    = b;
    bus.bit_valid = 1'b1;
    tick();
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
  endtask

  task automatic write_tbl(input logic [2:0] idx, input logic [6:0] sym,
                           input logic [14:0] code, input logic [14:0] mask);
    bus.tbl_we   = 1'b1;
    bus.tbl_idx  = idx;
    bus.tbl_sym  = sym;
    bus.tbl_code = code;
    bus.tbl_mask = mask;
    tick();
    bus.tbl_we   = 1'b0;
  endtask

  task automatic load_ae();
    write_tbl(3'd0, 7'h61, 15'h1, 15'h1);
    write_tbl(3'd1, 7'h65, 15'h0, 15'h3);
    write_tbl(3'd2, 7'h20, 15'h1, 15'h3);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Stream "ae aa": 1 | 00 | 01 | 1 | 1
    v[0] = '{b: 1'b1, ev: 1'b1, es: 7'h61};
    v[1] = '{b: 1'b0, ev: 1'b0, es: 7'h00};
    v[2] = '{b: 1'b0, ev: 1'b1, es: 7'h65};
    v[3] = '{b: 1'b0, ev: 1'b0, es: 7'h00};
    v[4] = '{b: 1'b1, ev: 1'b1, es: 7'h20};
    v[5] = '{b: 1'b1, ev: 1'b1, es: 7'h61};
    v[6] = '{b: 1'b1, ev: 1'b1, es: 7'h61};

    bus.tbl_we = 0; bus.tbl_idx = '0; bus.tbl_sym = '0; bus.tbl_code = '0;
    bus.tbl_mask = '0; bus.start = 0; bus.stop = 0; bus.bit_in = 0;
    bus.bit_valid = 0; bus.sym_ready = 0;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_sym_valid", bus.sym_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_bit_ready", bus.bit_ready, 0);
    chk("rst_sym_count", bus.sym_count, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_sym_out", bus.sym_out, 0);
    reset = 1'b0;
    tick();

    // Scenario 1: plain decode with sym_ready held high.
    load_ae();
    bus.sym_ready = 1'b1;
    pulse_start();
    chk("s1_busy", bus.busy, 1);
    chk("s1_bit_ready", bus.bit_ready, 1);
    for (int i = 0; i < 7; i++) begin
      send_bit(v[i].b);
      chk($sformatf("s1_valid[%0d]", i), bus.sym_valid, v[i].ev);
      if (v[i].ev) chk($sformatf("s1_sym[%0d]", i), bus.sym_out, v[i].es);
    end
    tick();
    chk("s1_count", bus.sym_count, 5);
    chk("s1_err", bus.err, 0);

    // Scenario 2: backpressure on the first symbol.
    pulse_stop();
    chk("s2_idle", bus.busy, 0);
    pulse_start();
    chk("s2_count_clr", bus.sym_count, 0);
    bus.sym_ready = 1'b0;
    send_bit(v[0].b);
    chk("s2_valid0", bus.sym_valid, 1);
    chk("s2_sym0", bus.sym_out, 7'h61);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("s2_hold_valid[%0d]", i), bus.sym_valid, 1);
      chk($sformatf("s2_hold_sym[%0d]", i), bus.sym_out, 7'h61);
      chk($sformatf("s2_hold_ready[%0d]", i), bus.bit_ready, 0);
    end
    bus.sym_ready = 1'b1;
    for (int i = 1; i < 7; i++) begin
      send_bit(v[i].b);
      chk($sformatf("s2_valid[%0d]", i), bus.sym_valid, v[i].ev);
      if (v[i].ev) chk($sformatf("s2_sym[%0d]", i), bus.sym_out, v[i].es);
    end
    tick();
    chk("s2_count", bus.sym_count, 5);

    // Scenario 3: only 'a' valid; fifteen zeros overflow the codeword.
    pulse_stop();
    write_tbl(3'd0, 7'h61, 15'h1, 15'h1);
    write_tbl(3'd1, 7'h00, 15'h0, 15'h0);
    write_tbl(3'd2, 7'h00, 15'h0, 15'h0);
    pulse_start();
    for (int i = 0; i < 14; i++) send_bit(1'b0);
    chk("s3_err_before", bus.err, 0);
    chk("s3_ready_before", bus.bit_ready, 1);
    send_bit(1'b0);
    chk("s3_err", bus.err, 1);
    chk("s3_bit_ready", bus.bit_ready, 0);
    chk("s3_sym_valid", bus.sym_valid, 0);
    chk("s3_busy", bus.busy, 1);
    chk("s3_count", bus.sym_count, 0);

    // Scenario 4: truncated codeword via stop, then recovery via start.
    pulse_stop();
    chk("s4_idle_busy", bus.busy, 0);
    chk("s4_idle_err_sticky", bus.err, 1);
    load_ae();
    pulse_start();
    chk("s4_err_clr", bus.err, 0);
    send_bit(1'b0);
    pulse_stop();
    chk("s4_err", bus.err, 1);
    chk("s4_bit_ready", bus.bit_ready, 0);
    chk("s4_busy", bus.busy, 1);
    pulse_start();
    chk("s4_restart_err", bus.err, 0);
    chk("s4_restart_count", bus.sym_count, 0);
    chk("s4_restart_ready", bus.bit_ready, 1);

    // Scenario 5: table write during DECODE must be ignored.
    write_tbl(3'd0, 7'h7A, 15'h1, 15'h1);
    bus.sym_ready = 1'b0;
    send_bit(1'b1);
    chk("s5_valid", bus.sym_valid, 1);
    chk("s5_sym", bus.sym_out, 7'h61);
    pulse_stop();
    chk("s5_stop_in_out_valid", bus.sym_valid, 1);
    chk("s5_stop_in_out_busy", bus.busy, 1);

    // Scenario 6: asynchronous reset while in OUT wipes the table.
    reset = 1'b1;
    #1;
    chk("s6_sym_valid", bus.sym_valid, 0);
    chk("s6_busy", bus.busy, 0);
    chk("s6_sym_out", bus.sym_out, 0);
    reset = 1'b0;
    tick();
    bus.sym_ready = 1'b1;
    pulse_start();
    send_bit(1'b1);
    chk("s6_no_sym", bus.sym_valid, 0);
    for (int i = 0; i < 13; i++) send_bit(1'b0);
    chk("s6_err_before", bus.err, 0);
    send_bit(1'b0);
    chk("s6_err", bus.err, 1);
    chk("s6_ready", bus.bit_ready, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
